note_judge: RTL and testbench
=============================

Name: note_judge

Overview:
- Per-lane note tracker and hit judge; sits downstream of the PS/2 keyboard decoder and the chart sequencer, and alongside the receptor block.
- Holds falling arrows for 4 lanes and scrolls them up once per video frame.
- Judges key presses against the receptor line and drives the score/combo displays.
- Drives per-lane arrow pixel flags into color_mapper.

Parameters:
DEPTH, 4, notes buffered per lane (circular buffer; power of 2)
SPAWN_Y, 448, Y of a newly spawned note's top edge
SPEED, 4, pixels moved up per frame
RECEPTOR_Y, 40, receptor line Y
WINDOW, 12, hit window half-width in pixels; RECEPTOR_Y-WINDOW >= SPEED is required
LANE_X0, 240, X of lane 0 left edge
LANE_PITCH, 40, X spacing between lanes
ARROW_SIZE, 32, arrow square side in pixels

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  asynchronous, active-low reset
frame_clk  in  1  VGA_VS (active-low vsync), asynchronous to Clk's logic; synchronised internally
keycode  in  8  PS/2 make code from keyboard
press  in  1  key held (level)
spawn_valid  in  1  chart sequencer offers a note
spawn_lane  in  2  lane of offered note
spawn_ready  out  1  note accepted this cycle when valid&ready
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
is_arrow  out  4  pixel lies in a live note of lane n
hit_pulse  out  1  one-cycle pulse per hit
miss_pulse  out  1  one-cycle pulse when one or more misses are culled in a frame
score  out  8  hit count, saturates at 255
combo  out  8  consecutive hits, saturates at 255; cleared on any miss

Behaviour:
- Reset (async assert, sync release):
  - All lane counts, head/tail pointers, score, combo and pulses are 0.
  - FSM goes to IDLE; pending key is cleared; spawn_ready=0.
- frame_clk passes through a 2-flop synchroniser. A frame tick is a 1-cycle pulse on each synchronised falling edge.
- Key event:
  - Registered rising edge of press.
  - Lane map: 0x6B→0 (left), 0x72→1 (down), 0x75→2 (up), 0x74→3 (right).
  - Any other keycode is ignored.
- FSM IDLE → SCROLL → CULL → IDLE; SCROLL and CULL last one cycle each.
  - IDLE:
    - A frame tick moves to SCROLL.
    - Otherwise, a key event or held pending event is judged.
  - SCROLL: every live entry y ← y − SPEED.
  - CULL:
    - Each lane whose head y < RECEPTOR_Y−WINDOW pops its head.
    - If any lane popped, miss_pulse=1 for 1 cycle and combo←0.
    - At most one pop per lane per frame.
- Judgement, in IDLE only, on the lane's head (oldest) note:
  - Hit when lane non-empty and RECEPTOR_Y−WINDOW ≤ y ≤ RECEPTOR_Y+WINDOW.
  - On hit: pop head, score+1 and combo+1 (both saturating), hit_pulse=1 the cycle after the event is judged.
  - Out-of-window or empty-lane presses have no effect and no penalty.
- Key event arriving while FSM is in SCROLL/CULL:
  - Latched into a 1-deep pending register and judged on return to IDLE.
  - A second event while one is pending overwrites it.
- Spawn:
  - spawn_ready = (state==IDLE) && count[spawn_lane] < DEPTH. It is combinational from state and counts.
  - On valid&ready the note is written at tail with y=SPAWN_Y, and count increments.
  - Spawn and hit-pop on the same lane in the same cycle are both honoured; count is unchanged.
  - A full lane holds ready low; the sequencer must hold valid.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- is_arrow[n] is combinational:
  - Set when any live entry e of lane n satisfies LANE_X0+n*LANE_PITCH ≤ DrawX < LANE_X0+n*LANE_PITCH+ARROW_SIZE.
  - And y_e ≤ DrawY < y_e+ARROW_SIZE.
- All Y arithmetic is 10-bit unsigned. The parameter constraint guarantees no underflow before cull.

Test Plan:
- Hold Reset_n=0 mid-scroll with 3 notes live → is_arrow=0, score=0, combo=0, spawn_ready=0. Release → spawn_ready=1.
- Spawn lane 2, run 100 frame ticks (y=48), then press with keycode 0x75 → hit_pulse once, score=1, combo=1, lane 2 empty.
- Spawn lane 0 and run 106 frames → miss_pulse once in CULL of frame 106 (y=24 <28), combo 5→0, score unchanged.
- Spawn 4 notes in lane 1 → spawn_ready low for lane 1 and high for lane 3. After a hit on lane 1, the 5th spawn is accepted.
- Key event (0x6B) asserted in the same cycle as the frame tick, head y=32 before scroll → judged after CULL at y=28, counted as a hit.
- At frame 0, DrawX=280, DrawY=448 → is_arrow=4'b0010 with a lane-1 note. At DrawX=312 → is_arrow=0.

Source files
------------

// File: rtl/note_judge.sv
`timescale 1ns/1ps
// note_judge: four-lane falling-note tracker. Scrolls notes once per video frame,
// culls missed notes, judges key presses at the receptor line and flags arrow pixels.
//
// state  | meaning
// IDLE   | judge key events, accept spawns, wait for a frame tick
// SCROLL | move every stored note up by SPEED
// CULL   | pop lane heads that have passed the hit window (misses)

module note_judge #(
  parameter int DEPTH      = 4,
  parameter int SPAWN_Y    = 448,
  parameter int SPEED      = 4,
  parameter int RECEPTOR_Y = 40,
  parameter int WINDOW     = 12,
  parameter int LANE_X0    = 240,
  parameter int LANE_PITCH = 40,
  parameter int ARROW_SIZE = 32
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       press,
  input  logic       spawn_valid,
  input  logic [1:0] spawn_lane,
  output logic       spawn_ready,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [3:0] is_arrow,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score,
  output logic [7:0] combo
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [9:0]    Y_SPAWN  = 10'(SPAWN_Y);
  localparam logic [9:0]    Y_SPEED  = 10'(SPEED);
  localparam logic [9:0]    Y_LO     = 10'(RECEPTOR_Y - WINDOW);
  localparam logic [9:0]    Y_HI     = 10'(RECEPTOR_Y + WINDOW);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    CULL   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [9:0]    y_mem  [4][DEPTH];
  logic [PW-1:0] head   [4];
  logic [PW-1:0] tail   [4];
  logic [CW-1:0] count  [4];
  logic [9:0]    head_y [4];
  logic [PW-1:0] offs   [4][DEPTH];
  logic [DEPTH-1:0] live [4];

  logic [2:0] fs;
  logic       tick;
  logic       run;
  logic       press_q;
  logic       map_ok;
  logic [1:0] map_lane;
  logic       evt_valid;
  logic [1:0] evt_lane;
  logic       pend_valid;
  logic [1:0] pend_lane;
  logic       cand_valid;
  logic [1:0] cand_lane;
  logic       judge_en;
  logic       scroll_en;
  logic       cull_en;
  logic       hit;
  logic       any_miss;
  logic       spawn_fire;
  logic [3:0] cull_pop;
  logic [3:0] pop;
  logic [3:0] push;

  // fs[1] is the synchronised frame_clk; fs[2] is its previous value
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs  <= 3'b111;
      run <= 1'b0;
    end else begin
      fs  <= {fs[1:0], frame_clk};
      run <= 1'b1;
    end
  end

  assign tick = fs[2] & ~fs[1];

  always_comb begin
    map_ok   = 1'b1;
    map_lane = 2'd0;
    case (keycode)
      8'h6B:   map_lane = 2'd0;
      8'h72:   map_lane = 2'd1;
      8'h75:   map_lane = 2'd2;
      8'h74:   map_lane = 2'd3;
      default: map_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      press_q   <= 1'b0;
      evt_valid <= 1'b0;
      evt_lane  <= 2'd0;
    end else begin
      press_q   <= press;
      evt_valid <= press & ~press_q & map_ok;
      evt_lane  <= map_lane;
    end
  end

  // A fresh event takes precedence over an older pending one
  assign cand_valid = evt_valid | pend_valid;
  assign cand_lane  = evt_valid ? evt_lane : pend_lane;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    judge_en   = 1'b0;
    scroll_en  = 1'b0;
    cull_en    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) state_next = SCROLL;
        else      judge_en   = cand_valid;
      end
      SCROLL: begin
        scroll_en  = 1'b1;
        state_next = CULL;
      end
      CULL: begin
        cull_en    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_valid <= 1'b0;
      pend_lane  <= 2'd0;
    end else if (evt_valid && !judge_en) begin
      pend_valid <= 1'b1;
      pend_lane  <= evt_lane;
    end else if (judge_en) begin
      pend_valid <= 1'b0;
    end
  end

  assign spawn_ready = run && (state == IDLE) && (count[spawn_lane] < CNT_FULL);
  assign spawn_fire  = spawn_valid & spawn_ready;

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      head_y[l] = y_mem[l][head[l]];
    end
  end

  always_comb begin
    hit      = 1'b0;
    cull_pop = '0;
    pop      = '0;
    push     = '0;
    if (judge_en && (count[cand_lane] != '0) &&
        (head_y[cand_lane] >= Y_LO) && (head_y[cand_lane] <= Y_HI)) begin
      hit = 1'b1;
    end
    for (int l = 0; l < 4; l++) begin
      cull_pop[l] = cull_en && (count[l] != '0) && (head_y[l] < Y_LO);
      pop[l]      = cull_pop[l] | (hit && (cand_lane == 2'(l)));
      push[l]     = spawn_fire && (spawn_lane == 2'(l));
    end
  end

  assign any_miss = |cull_pop;

  // Spawn and pop on one lane in the same cycle leave the count unchanged
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int l = 0; l < 4; l++) begin
        head[l]  <= '0;
        tail[l]  <= '0;
        count[l] <= '0;
        for (int i = 0; i < DEPTH; i++) y_mem[l][i] <= '0;
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (scroll_en) begin
          for (int i = 0; i < DEPTH; i++) y_mem[l][i] <= y_mem[l][i] - Y_SPEED;
        end
        if (push[l]) begin
          y_mem[l][tail[l]] <= Y_SPAWN;
          tail[l]           <= tail[l] + PW'(1);
        end
        if (pop[l]) head[l] <= head[l] + PW'(1);
        if (push[l] && !pop[l])      count[l] <= count[l] + CW'(1);
        else if (pop[l] && !push[l]) count[l] <= count[l] - CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score      <= 8'd0;
      combo      <= 8'd0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      hit_pulse  <= hit;
      miss_pulse <= any_miss;
      if (hit && (score != 8'hFF)) score <= score + 8'd1;
      if (any_miss)                      combo <= 8'd0;
      else if (hit && (combo != 8'hFF))  combo <= combo + 8'd1;
    end
  end

  // Entry i is live when its distance from head is below the lane count
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < DEPTH; i++) begin
        offs[l][i] = PW'(i) - head[l];
        live[l][i] = CW'(offs[l][i]) < count[l];
      end
    end
  end

  always_comb begin
    is_arrow = '0;
    for (int l = 0; l < 4; l++) begin
      if ((int'(DrawX) >= LANE_X0 + l * LANE_PITCH) &&
          (int'(DrawX) <  LANE_X0 + l * LANE_PITCH + ARROW_SIZE)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (live[l][i] &&
              (int'(DrawY) >= int'(y_mem[l][i])) &&
              (int'(DrawY) <  int'(y_mem[l][i]) + ARROW_SIZE)) begin
            is_arrow[l] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_note_judge.sv
`timescale 1ns/1ps
// tb_note_judge: directed bench for note_judge covering reset, hits, misses,
// full-lane back-pressure, pending key events and arrow pixel flags.

module tb_note_judge;

  logic       Clk         = 1'b0;
  logic       Reset_n     = 1'b0;
  logic       frame_clk   = 1'b1;
  logic [7:0] keycode     = 8'h00;
  logic       press       = 1'b0;
  logic       spawn_valid = 1'b0;
  logic [1:0] spawn_lane  = 2'd0;
  logic [9:0] DrawX       = 10'd0;
  logic [9:0] DrawY       = 10'd0;
  logic       spawn_ready;
  logic [3:0] is_arrow;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] score;
  logic [7:0] combo;

  int checks    = 0;
  int failures  = 0;
  int hit_seen  = 0;
  int miss_seen = 0;
  int h0        = 0;
  int m0        = 0;

  note_judge dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .press       (press),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_ready (spawn_ready),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .is_arrow    (is_arrow),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .score       (score),
    .combo       (combo)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (hit_pulse)  hit_seen++;
    if (miss_pulse) miss_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_clk = 1'b0;
      cyc(2);
      frame_clk = 1'b1;
      cyc(4);
    end
  endtask

  task automatic spawn(input logic [1:0] lane);
    spawn_lane  = lane;
    spawn_valid = 1'b1;
    cyc(1);
    spawn_valid = 1'b0;
  endtask

  task automatic key(input logic [7:0] code);
    keycode = code;
    press   = 1'b1;
    cyc(3);
    press   = 1'b0;
    cyc(1);
  endtask

  initial begin
    cyc(3);
    Reset_n = 1'b1;
    cyc(1);
    check("ready_after_por", spawn_ready, 1'b1);

    // Reset asserted while the FSM is scrolling with three notes live
    spawn(2'd0);
    spawn(2'd1);
    spawn(2'd2);
    DrawX = 10'd240; DrawY = 10'd448; #1;
    check("arrow_lane0_spawned", is_arrow, 4'b0001);
    frame_clk = 1'b0;
    cyc(3);
    Reset_n = 1'b0;
    #1;
    check("rst_is_arrow", is_arrow, 4'b0000);
    check("rst_score", score, 8'd0);
    check("rst_combo", combo, 8'd0);
    check("rst_ready", spawn_ready, 1'b0);
    frame_clk = 1'b1;
    cyc(2);
    Reset_n = 1'b1;
    cyc(1);
    check("ready_after_release", spawn_ready, 1'b1);

    // Lane 2: early press, ignored keycode, then an in-window hit at y=48
    spawn(2'd2);
    frames(97);
    DrawX = 10'd320; DrawY = 10'd60; #1;
    check("lane2_at_y60", is_arrow, 4'b0100);
    key(8'h75);
    check("early_press_score", score, 8'd0);
    frames(3);
    DrawY = 10'd48; #1;
    check("lane2_at_y48", is_arrow, 4'b0100);
    key(8'h1C);
    check("bad_key_score", score, 8'd0);
    h0 = hit_seen;
    key(8'h75);
    check("lane2_hit_pulses", hit_seen - h0, 1);
    check("lane2_hit_score", score, 8'd1);
    check("lane2_hit_combo", combo, 8'd1);
    #1;
    check("lane2_empty", is_arrow, 4'b0000);

    // Lane 1 filled to DEPTH: back-pressure, hit at upper window edge y=52
    spawn(2'd1); spawn(2'd1); spawn(2'd1); spawn(2'd1);
    spawn_lane = 2'd1; #1;
    check("lane1_full_ready", spawn_ready, 1'b0);
    spawn_lane = 2'd3; #1;
    check("lane3_ready", spawn_ready, 1'b1);
    frames(99);
    key(8'h72);
    check("edge52_score", score, 8'd2);
    check("edge52_combo", combo, 8'd2);
    spawn_lane = 2'd1; #1;
    check("lane1_ready_after_hit", spawn_ready, 1'b1);
    spawn(2'd1);
    key(8'h72);
    key(8'h72);
    key(8'h72);
    check("lane1_drain_score", score, 8'd5);
    check("lane1_drain_combo", combo, 8'd5);

    // Arrow pixel flags at frame 0 (lane-1 and lane-0 notes both at y=448)
    spawn(2'd0);
    DrawX = 10'd280; DrawY = 10'd448; #1;
    check("px_280_448", is_arrow, 4'b0010);
    DrawY = 10'd479; #1;
    check("px_280_479", is_arrow, 4'b0010);
    DrawY = 10'd480; #1;
    check("px_280_480", is_arrow, 4'b0000);
    DrawX = 10'd312; DrawY = 10'd448; #1;
    check("px_312_448", is_arrow, 4'b0000);

    // Both notes sit at y=28 after 105 frames (kept) and y=24 after 106 (culled)
    m0 = miss_seen;
    frames(105);
    check("no_miss_at_28", miss_seen - m0, 0);
    check("combo_before_miss", combo, 8'd5);
    frames(1);
    check("miss_pulses", miss_seen - m0, 1);
    check("combo_after_miss", combo, 8'd0);
    check("score_after_miss", score, 8'd5);
    DrawX = 10'd280; DrawY = 10'd24; #1;
    check("culled_lanes_empty", is_arrow, 4'b0000);

    // Key event coincides with the frame tick: pending, judged at y=28
    spawn(2'd0);
    frames(104);
    DrawX = 10'd240; DrawY = 10'd32; #1;
    check("lane0_at_y32", is_arrow, 4'b0001);
    h0 = hit_seen;
    m0 = miss_seen;
    frame_clk = 1'b0;
    cyc(1);
    keycode = 8'h6B;
    press   = 1'b1;
    cyc(1);
    frame_clk = 1'b1;
    cyc(5);
    press = 1'b0;
    cyc(1);
    check("pending_hit_pulses", hit_seen - h0, 1);
    check("pending_miss_pulses", miss_seen - m0, 0);
    check("pending_score", score, 8'd6);
    check("pending_combo", combo, 8'd1);
    DrawY = 10'd28; #1;
    check("pending_lane0_empty", is_arrow, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
